// File: rtl/cache_fill_arbiter_if.sv
// cache_fill_arbiter_if
//   Request, memory and cache-fill signals between the miss arbiter and its
//   neighbours (I/D caches, store buffer, main memory).
//   master : arbiter side (drives memory and fill signals, reads requests)
//   slave  : environment side (drives requests and memory returns)
interface cache_fill_arbiter_if;
  // requesters
  logic        i_miss;
  logic [15:0] i_miss_addr;
  logic        d_miss;
  logic [15:0] d_miss_addr;
  logic        d_wr_req;
  logic [15:0] d_wr_addr;
  logic [15:0] d_wr_data;
  // main memory
  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  // cache fill
  logic [15:0] fill_data;
  logic [2:0]  fill_word_sel;
  logic [11:0] fill_line_addr;
  logic        i_fill_we;
  logic        d_fill_we;
  logic        i_tag_we;
  logic        d_tag_we;
  logic        i_done;
  logic        d_done;
  logic        wr_ack;
  logic        busy;

  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr, d_wr_req, d_wr_addr, d_wr_data,
    input  mem_data_out, mem_data_valid,
    output mem_addr, mem_enable, mem_wr, mem_data_in,
    output fill_data, fill_word_sel, fill_line_addr, i_fill_we, d_fill_we,
    output i_tag_we, d_tag_we, i_done, d_done, wr_ack, busy
  );

  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, d_wr_req, d_wr_addr, d_wr_data,
    output mem_data_out, mem_data_valid,
    input  mem_addr, mem_enable, mem_wr, mem_data_in,
    input  fill_data, fill_word_sel, fill_line_addr, i_fill_we, d_fill_we,
    input  i_tag_we, d_tag_we, i_done, d_done, wr_ack, busy
  );
endinterface

// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter
//   Single owner of the shared main memory. Arbitrates I-miss > D-store >
//   D-miss, issues 8 pipelined word reads per line fill, streams returned words
//   into the owning cache, then pulses that cache's tag write and done.
//   Ports: clk, rst_n (async, active low), bus (cache_fill_arbiter_if.master).
//   MEM_LAT: fixed memory read latency in cycles.
module cache_fill_arbiter #(
  parameter int MEM_LAT = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  cache_fill_arbiter_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FILL, S_DONE} state_e;

  // Earliest a return can legitimately arrive is MEM_LAT issues after the
  // matching read; capped at 8 since the issue count saturates there.
  localparam logic [4:0] LAT5 = (MEM_LAT > 8) ? 5'd8 : 5'(MEM_LAT);

  state_e      state_q;
  logic        owner_q;   // 0: I-cache, 1: D-cache
  logic [11:0] line_q;
  logic [3:0]  iss_q;
  logic [3:0]  rcv_q;

  logic       issuing, accept, in_write, in_done, in_line;
  logic [4:0] rcv_need, rcv_sum;

  assign in_write = (state_q == S_WRITE);
  assign in_done  = (state_q == S_DONE);
  assign in_line  = (state_q == S_FILL) || in_done;
  assign issuing  = (state_q == S_FILL) && !iss_q[3];

  // A return whose read cannot have been issued MEM_LAT cycles ago is stale
  // (e.g. left over from a fill aborted by reset) and is dropped.
  assign rcv_sum  = {1'b0, rcv_q} + LAT5;
  assign rcv_need = (rcv_sum > 5'd8) ? 5'd8 : rcv_sum;
  assign accept   = (state_q == S_FILL) && bus.mem_data_valid && !rcv_q[3] &&
                    ({1'b0, iss_q} >= rcv_need);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      line_q  <= '0;
      iss_q   <= '0;
      rcv_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_miss) begin
            owner_q <= 1'b0;
            line_q  <= bus.i_miss_addr[15:4];
            iss_q   <= '0;
            rcv_q   <= '0;
            state_q <= S_FILL;
          end else if (bus.d_wr_req) begin
            state_q <= S_WRITE;
          end else if (bus.d_miss) begin
            owner_q <= 1'b1;
            line_q  <= bus.d_miss_addr[15:4];
            iss_q   <= '0;
            rcv_q   <= '0;
            state_q <= S_FILL;
          end
        end
        S_WRITE: state_q <= S_IDLE;
        S_FILL: begin
          if (issuing) iss_q <= iss_q + 4'd1;
          if (accept) begin
            rcv_q <= rcv_q + 4'd1;
            if (rcv_q == 4'd7) state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Memory port: store in WRITE, line reads (word 0..7) while issuing.
  assign bus.mem_enable  = issuing || in_write;
  assign bus.mem_wr      = in_write;
  assign bus.mem_addr    = in_write ? bus.d_wr_addr :
                           issuing  ? {line_q, iss_q[2:0], 1'b0} : 16'h0000;
  assign bus.mem_data_in = in_write ? bus.d_wr_data : 16'h0000;
  assign bus.wr_ack      = in_write;

  // Fill path
  assign bus.fill_data      = accept ? bus.mem_data_out : 16'h0000;
  assign bus.fill_word_sel  = accept ? rcv_q[2:0] : 3'd0;
  assign bus.fill_line_addr = in_line ? line_q : 12'h000;
  assign bus.i_fill_we      = accept && !owner_q;
  assign bus.d_fill_we      = accept &&  owner_q;
  assign bus.i_tag_we       = in_done && !owner_q;
  assign bus.d_tag_we       = in_done &&  owner_q;
  assign bus.i_done         = in_done && !owner_q;
  assign bus.d_done         = in_done &&  owner_q;
  assign bus.busy           = (state_q != S_IDLE);

  // word offset bits of miss addresses are not needed: fills always start at word 0
  logic unused_addr_lo;
  assign unused_addr_lo = ^{bus.i_miss_addr[3:0], bus.d_miss_addr[3:0]};

endmodule

// File: tb/tb_cache_fill_arbiter.sv
module tb_cache_fill_arbiter;
  localparam int L = 4;
  localparam int K_RD = 0, K_WR = 1, K_FWE = 2, K_TAG = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_fill_arbiter_if bus();
  cache_fill_arbiter #(.MEM_LAT(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    int          kind;
    bit          o;
    logic [15:0] a;
    logic [15:0] d;
    logic [2:0]  sel;
  } ev_t;
  ev_t exp_q[$];

  // ---------------- memory contents ----------------
  function automatic logic [15:0] base(logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction
  logic [15:0] mem_w [logic [15:0]];   // what the memory model holds
  logic [15:0] ref_w [logic [15:0]];   // what the reference expects

  // ---------------- memory model ----------------
  logic        pv [L] = '{default: 1'b0};
  logic [15:0] pa [L] = '{default: 16'h0};
  logic        nxt_v = 1'b0;
  logic [15:0] nxt_d = 16'h0;
  logic        spur = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_enable && bus.mem_wr) mem_w[bus.mem_addr] = bus.mem_data_in;
    for (int k = L - 1; k > 0; k--) begin
      pv[k] = pv[k-1];
      pa[k] = pa[k-1];
    end
    pv[0] = bus.mem_enable && !bus.mem_wr;
    pa[0] = bus.mem_addr;
    nxt_v = pv[L-1];
    nxt_d = mem_w.exists(pa[L-1]) ? mem_w[pa[L-1]] : base(pa[L-1]);
  end

  always @(posedge clk) begin
    #2;
    bus.mem_data_valid = nxt_v | spur;
    bus.mem_data_out   = nxt_v ? nxt_d : (spur ? 16'hDEAD : 16'h0);
  end

  // ---------------- check helpers ----------------
  task automatic chk(string nm, logic [79:0] act, logic [79:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, req);
    end
  endtask

  task automatic got(int kind, bit o, logic [15:0] a, logic [15:0] d, logic [2:0] sel);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event cyc=%0d got kind=%0d a=%0h want none", cyc, kind, a);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", 80'(kind), 80'(e.kind));
      chk("ev_cycle", 80'(cyc), 80'(e.cyc));
      chk("ev_owner", 80'(o), 80'(e.o));
      chk("ev_addr", 80'(a), 80'(e.a));
      chk("ev_data", 80'(d), 80'(e.d));
      chk("ev_sel", 80'(sel), 80'(e.sel));
    end
  endtask

  function automatic logic [79:0] all_out();
    return 80'({bus.mem_addr, bus.mem_enable, bus.mem_wr, bus.mem_data_in, bus.fill_data,
                bus.fill_word_sel, bus.fill_line_addr, bus.i_fill_we, bus.d_fill_we,
                bus.i_tag_we, bus.d_tag_we, bus.i_done, bus.d_done, bus.wr_ack, bus.busy});
  endfunction

  // ---------------- reference model ----------------
  // Transaction-level: a grant at cycle c books the memory until c+10+L for
  // a fill or c+2 for a store, and lays out that transaction's events in time.
  int free = 0;
  int gnt = -1;

  function automatic logic [15:0] ref_rd(logic [15:0] a);
    return ref_w.exists(a) ? ref_w[a] : base(a);
  endfunction

  task automatic push_fill(bit o, logic [15:0] addr);
    ev_t e;
    logic [15:0] wa;
    for (int t = cyc + 1; t <= cyc + 9 + L; t++) begin
      if (t <= cyc + 8) begin
        wa = {addr[15:4], 4'h0} + 16'(2 * (t - cyc - 1));
        e = '{cyc: t, kind: K_RD, o: 1'b0, a: wa, d: 16'h0, sel: 3'd0};
        exp_q.push_back(e);
      end
      if (t >= cyc + 1 + L && t <= cyc + 8 + L) begin
        wa = {addr[15:4], 4'h0} + 16'(2 * (t - cyc - 1 - L));
        e = '{cyc: t, kind: K_FWE, o: o, a: {4'h0, addr[15:4]}, d: ref_rd(wa),
              sel: 3'(t - cyc - 1 - L)};
        exp_q.push_back(e);
      end
      if (t == cyc + 9 + L) begin
        e = '{cyc: t, kind: K_TAG, o: o, a: {4'h0, addr[15:4]}, d: 16'h0, sel: 3'd0};
        exp_q.push_back(e);
      end
    end
    gnt  = cyc;
    free = cyc + 10 + L;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs_zero", all_out(), 80'h0);
      exp_q.delete();
      free = 0;
      gnt  = -1;
    end else begin
      if (cyc >= free) begin
        chk("idle_outputs_zero", all_out(), 80'h0);
        if (bus.i_miss) push_fill(1'b0, bus.i_miss_addr);
        else if (bus.d_wr_req) begin
          exp_q.push_back('{cyc: cyc + 1, kind: K_WR, o: 1'b0, a: bus.d_wr_addr,
                            d: bus.d_wr_data, sel: 3'd0});
          ref_w[bus.d_wr_addr] = bus.d_wr_data;
          gnt  = cyc;
          free = cyc + 2;
        end else if (bus.d_miss) push_fill(1'b1, bus.d_miss_addr);
      end else if (cyc > gnt) begin
        chk("busy", 80'(bus.busy), 80'h1);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_event cyc=%0d got nothing want kind=%0d at cyc=%0d",
                 cyc, exp_q[0].kind, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (bus.mem_enable && !bus.mem_wr && !bus.wr_ack)
        got(K_RD, 1'b0, bus.mem_addr, 16'h0, 3'd0);
      if (bus.mem_wr || bus.wr_ack) begin
        chk("write_strobes", 80'({bus.mem_enable, bus.mem_wr, bus.wr_ack}), 80'h7);
        got(K_WR, 1'b0, bus.mem_addr, bus.mem_data_in, 3'd0);
      end
      if (bus.i_fill_we || bus.d_fill_we) begin
        chk("fill_we_onehot", 80'(bus.i_fill_we & bus.d_fill_we), 80'h0);
        got(K_FWE, bus.d_fill_we, {4'h0, bus.fill_line_addr}, bus.fill_data, bus.fill_word_sel);
      end
      if (bus.i_tag_we || bus.d_tag_we || bus.i_done || bus.d_done) begin
        chk("tag_done_pulse", 80'({bus.i_tag_we, bus.i_done, bus.d_tag_we, bus.d_done}),
            (bus.d_tag_we | bus.d_done) ? 80'h3 : 80'hC);
        got(K_TAG, bus.d_tag_we | bus.d_done, {4'h0, bus.fill_line_addr}, 16'h0, 3'd0);
      end
    end
    cyc++;
  end

  // ---------------- requesters ----------------
  task automatic timeout(string nm);
    checks++;
    failures++;
    $display("FAIL %s_timeout cyc=%0d got no response want response", nm, cyc);
  endtask

  task automatic do_imiss(logic [15:0] a);
    bit seen = 0;
    @(posedge clk); #1;
    bus.i_miss = 1'b1; bus.i_miss_addr = a;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      seen = bus.i_done;
    end
    if (!seen) timeout("i_miss");
    @(posedge clk); #1;
    bus.i_miss = 1'b0;
  endtask

  task automatic do_dmiss(logic [15:0] a);
    bit seen = 0;
    @(posedge clk); #1;
    bus.d_miss = 1'b1; bus.d_miss_addr = a;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      seen = bus.d_done;
    end
    if (!seen) timeout("d_miss");
    @(posedge clk); #1;
    bus.d_miss = 1'b0;
  endtask

  task automatic do_dwr(logic [15:0] a, logic [15:0] d);
    bit seen = 0;
    @(posedge clk); #1;
    bus.d_wr_req = 1'b1; bus.d_wr_addr = a; bus.d_wr_data = d;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      seen = bus.wr_ack;
    end
    if (!seen) timeout("d_wr");
    @(posedge clk); #1;
    bus.d_wr_req = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] ai, aw, dw, ad;
  logic [2:0]  mask;

  initial begin
    bus.i_miss = 0; bus.i_miss_addr = 0;
    bus.d_miss = 0; bus.d_miss_addr = 0;
    bus.d_wr_req = 0; bus.d_wr_addr = 0; bus.d_wr_data = 0;
    bus.mem_data_valid = 0; bus.mem_data_out = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // single I miss, line 0x123
    do_imiss(16'h1236);
    idle(2);

    // all three at once: I fill, then store, then D fill
    fork
      do_imiss(16'h2A38);
      do_dwr(16'h7770, 16'h1357);
      do_dmiss(16'h3C4E);
    join
    idle(2);

    // store then read it back through a D fill
    do_dwr(16'h4000, 16'hBEEF);
    do_dmiss(16'h4000);
    idle(2);

    // D miss withdrawn at cycle 4; fill still completes, no regrant
    @(posedge clk); #1;
    bus.d_miss = 1'b1; bus.d_miss_addr = 16'h5A52;
    repeat (4) @(posedge clk);
    #1 bus.d_miss = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    idle(3);

    // async reset at cycle 6 of a fill
    @(posedge clk); #1;
    bus.d_miss = 1'b1; bus.d_miss_addr = 16'h6610;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_reset_immediate", all_out(), 80'h0);
    bus.d_miss = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(8);                         // late returns arrive while idle
    do_imiss(16'h6614);
    idle(2);

    // spurious returns in IDLE and across a store
    spur = 1'b1;
    idle(3);
    do_dwr(16'h0102, 16'hA5A5);
    spur = 1'b0;
    idle(2);

    // random mixes
    for (int it = 0; it < 15; it++) begin
      mask = 3'($urandom_range(1, 7));
      ai = 16'($urandom); aw = 16'($urandom); dw = 16'($urandom); ad = 16'($urandom);
      if (it % 4 == 3) ad = aw;      // read back a fresh store now and then
      fork
        begin if (mask[0]) do_imiss(ai); end
        begin if (mask[1]) do_dwr(aw, dw); end
        begin if (mask[2]) do_dmiss(ad); end
      join
      idle(int'($urandom_range(0, 3)));
    end

    idle(5);
    chk("scoreboard_drained", 80'(exp_q.size()), 80'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d got running want finished", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cache_fill_arbiter.md
# cache_fill_arbiter

Miss-service controller between the instruction/data caches and the single shared 4-cycle main memory. It arbitrates I-cache miss, D-cache miss and D-side write-through store requests. It drives pipelined memory reads to fetch an 8-word line. It streams each returned word into the owning cache with a word select, then pulses that cache's tag write. Only one memory transaction owner exists at a time; this block is the sole driver of the memory ports.

## Interface

**Parameters**
- `MEM_LAT`, default 4: memory read latency; data for a read issued in cycle t has `mem_data_valid` high in cycle t+MEM_LAT.

**Ports**
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `i_miss`, in, 1: I-cache miss request, level.
- `i_miss_addr`, in, 16: I-side miss address.
- `d_miss`, in, 1: D-cache miss request, level.
- `d_miss_addr`, in, 16: D-side miss address.
- `d_wr_req`, in, 1: write-through store request, level.
- `d_wr_addr`, in, 16: store address.
- `d_wr_data`, in, 16: store data.
- `mem_addr`, out, 16: memory address.
- `mem_enable`, out, 1: memory access enable.
- `mem_wr`, out, 1: memory write.
- `mem_data_in`, out, 16: memory write data.
- `mem_data_out`, in, 16: memory read data.
- `mem_data_valid`, in, 1: read data valid.
- `fill_data`, out, 16: word to write into the cache; equals `mem_data_out`.
- `fill_word_sel`, out, 3: word index within the line.
- `fill_line_addr`, out, 12: latched miss address [15:4].
- `i_fill_we`, out, 1: I-cache data write enable.
- `d_fill_we`, out, 1: D-cache data write enable.
- `i_tag_we`, out, 1: I-cache tag/valid write, 1-cycle pulse.
- `d_tag_we`, out, 1: D-cache tag/valid write, 1-cycle pulse.
- `i_done`, out, 1: I fill complete, 1-cycle pulse.
- `d_done`, out, 1: D fill complete, 1-cycle pulse.
- `wr_ack`, out, 1: store accepted, 1-cycle pulse.
- `busy`, out, 1: state is not IDLE.

## Operation

- **States:** IDLE, WRITE, FILL, DONE. State, owner flag (I/D), line address, issue counter (0..8) and receive counter (0..8) are all registered.
- **IDLE:** samples requests with fixed priority i_miss > d_wr_req > d_miss.
  - Granting a miss latches owner and addr[15:4], clears both counters, and goes to FILL.
  - Granting a store goes to WRITE.
  - With no request, stays in IDLE.
- **WRITE:** one cycle.
  - Drives `mem_enable`=1, `mem_wr`=1, `mem_addr`=d_wr_addr, `mem_data_in`=d_wr_data, `wr_ack`=1.
  - Then goes to IDLE.
- **FILL, issue side:** while issue count < 8, drives `mem_enable`=1, `mem_wr`=0, `mem_addr`={line, issue[2:0], 1'b0}, and increments the issue count. One read is issued per cycle; reads are pipelined.
- **FILL, receive side:** on `mem_data_valid`, asserts the owner's `*_fill_we` with `fill_word_sel`=recv[2:0], then increments the receive count. When the 8th word is received, goes to DONE.
- **DONE:** one cycle. Pulses the owner's `*_tag_we` and `*_done`, then goes to IDLE.
- **Requester rule:** a requester holds its request and address stable until it sees done/ack, and deasserts in the following cycle. The arbiter always spends that cycle in IDLE, so there is no double grant.
- **Boundaries:**
  - A request dropped mid-FILL is ignored; the fill completes anyway.
  - `mem_data_valid` outside FILL, or after 8 words, is ignored.
  - A new request arriving while busy waits; it is not lost because requests are level.
  - Word address wraps within the line. The issue order is always word 0 to word 7, regardless of the miss word.
- **Reset:** asynchronous, mid-operation included. Forces IDLE and clears counters, owner and line. In-flight memory returns are then ignored.

## Timing

- All outputs are 0 during reset and in IDLE with no grant.
- `fill_data`, `*_fill_we` and `fill_word_sel` are combinational from state, owner, counters and `mem_data_valid`. All other outputs are decoded from registered state/counters.
- **Fill latency**, with request seen in IDLE at cycle 0:
  - FILL occupies cycles 1..8+MEM_LAT.
  - Reads are issued in cycles 1..8.
  - Words return in cycles 1+MEM_LAT..8+MEM_LAT.
  - DONE is at cycle 9+MEM_LAT, which is 13 for the default.
  - Back in IDLE at 10+MEM_LAT.
- **Store:** WRITE plus `wr_ack` in cycle 1; IDLE in cycle 2.

## Test plan

- **Reset then single I miss:** `i_miss`=1, addr 0x1236 at cycle 0.
  - `mem_addr` is 0x1230, 0x1232 … 0x123E in cycles 1–8.
  - `i_fill_we` is asserted with sel 0..7 in cycles 5–12.
  - `i_tag_we` and `i_done` pulse at cycle 13; `fill_line_addr`=0x123.
- **Simultaneous `i_miss`, `d_miss` and `d_wr_req`:**
  - The I fill runs first.
  - Then WRITE, with `mem_wr`=1 and `wr_ack`.
  - Then the D fill, with `d_fill_we` only and no `i_fill_we`.
- **Store with memory model check:** `d_wr_req`, addr 0x4000, data 0xBEEF.
  - `mem_enable`=`mem_wr`=1 for exactly 1 cycle.
  - A subsequent D miss to 0x4000 returns 0xBEEF as word 0.
- **Request withdrawn mid-fill:** drop `d_miss` at cycle 4.
  - All 8 `d_fill_we` pulses still occur, plus `d_tag_we`.
  - No regrant afterwards.
- **Async reset at cycle 6 of a fill:**
  - All outputs are 0 immediately.
  - Late `mem_data_valid` pulses produce no `*_fill_we`.
  - A new miss after release fills normally.
- **Spurious `mem_data_valid` in IDLE and WRITE:** no fill enables and no state change.
